// File: rtl/fifo_ptr_pkg.sv
// ----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared definitions for the FIFO pointer controller:
//   - cnt_width()   : occupancy counter width for a given pointer width
//                     (one extra bit so that count can reach DEPTH)
//   - depth_legal() : elaboration-time legality check for DEPTH
//   - reset constants for pointers and status flags
// ----------------------------------------------------------------------------
package fifo_ptr_pkg;

  // Pointer reset value (cast to ADDR_W at the point of use)
  localparam int unsigned PTR_RST = 0;

  // Status flag reset values: an empty FIFO is empty and almost-empty
  localparam logic FULL_RST  = 1'b0;
  localparam logic EMPTY_RST = 1'b1;
  localparam logic AF_RST    = 1'b0;
  localparam logic AE_RST    = 1'b1;
  localparam logic ERR_RST   = 1'b0;

  // Occupancy needs to represent 0..DEPTH, and DEPTH may equal 2^ADDR_W
  function automatic int unsigned cnt_width(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  // DEPTH must lie in 2..2^ADDR_W
  function automatic bit depth_legal(input int unsigned addr_w,
                                     input longint unsigned depth);
    return (depth >= 64'd2) && (depth <= (64'd1 << addr_w));
  endfunction

endpackage : fifo_ptr_pkg

// File: rtl/fifo_ptr_ctrl_ptr_wrap_inc.sv
// ----------------------------------------------------------------------------
// ptr_wrap_inc
// Combinational wrap-aware pointer increment. Wraps at DEPTH-1 rather than at
// 2^ADDR_W, so DEPTH need not be a power of two.
// Parameters: ADDR_W (pointer width), DEPTH (number of entries)
// Ports:
//   ptr_i  in  ADDR_W  current pointer (always < DEPTH)
//   nxt_o  out ADDR_W  pointer after one advance
// ----------------------------------------------------------------------------
module ptr_wrap_inc #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [ADDR_W-1:0] ptr_i,
  output logic [ADDR_W-1:0] nxt_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  // Advance pointer, returning to zero after the last legal index
  always_comb begin
    nxt_o = ptr_i;
    if (ptr_i == LAST_IDX) begin
      nxt_o = '0;
    end else begin
      nxt_o = ptr_i + ADDR_W'(1);
    end
  end

endmodule : ptr_wrap_inc

// File: rtl/fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ptr_ctrl
// Registered read/write pointer controller for the lab FIFO. Owns both
// pointers (wrapping at DEPTH), tracks occupancy and derives registered
// full / empty / almost_full / almost_empty flags from the next occupancy.
//
// Optional feature: define FIFO_PTR_ERR_EN to build sticky overflow /
// underflow error flags. Without it both outputs are tied to 0.
//
// Parameters: ADDR_W, DEPTH (2..2^ADDR_W), AF_LVL, AE_LVL
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   push, pop      in   write / read requests
//   wr_addr        out  write pointer (memory write address)
//   rd_addr        out  read pointer (head entry while !empty)
//   wr_en, rd_en   out  combinational accepted push / pop
//   count          out  registered occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty  out  registered flags
//   overflow, underflow                     out  sticky error flags
// ----------------------------------------------------------------------------
module fifo_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [ADDR_W-1:0]                 rd_addr,
  output logic                              wr_en,
  output logic                              rd_en,
  output logic [cnt_width(ADDR_W)-1:0]      count,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int CNT_W = cnt_width(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LVL);

  if (!depth_legal(ADDR_W, DEPTH)) begin : g_bad_depth
    $error("fifo_ptr_ctrl: DEPTH must be in 2..2^ADDR_W");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;

  ptr_wrap_inc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_inc (
    .ptr_i (wr_ptr_q),
    .nxt_o (wr_ptr_inc)
  );

  ptr_wrap_inc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_inc (
    .ptr_i (rd_ptr_q),
    .nxt_o (rd_ptr_inc)
  );

  // Acceptance uses the registered (pre-edge) flags. Gating with rst_n keeps
  // the memory from being written while reset is held.
  assign wr_en = push & ~full_q  & rst_n;
  assign rd_en = pop  & ~empty_q & rst_n;

  // Next pointer, occupancy and flag values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_inc;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_inc;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous accepted push and pop leave occupancy unchanged
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags follow the next occupancy so they line up with count
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == CNT_W'(0));
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= ADDR_W'(PTR_RST);
      rd_ptr_q <= ADDR_W'(PTR_RST);
      count_q  <= '0;
      full_q   <= FULL_RST;
      empty_q  <= EMPTY_RST;
      af_q     <= AF_RST;
      ae_q     <= AE_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

`ifdef FIFO_PTR_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: set on a rejected request, cleared only by reset
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (push && full_q) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (pop && empty_q) begin
      udf_d = 1'b1;
    end else begin
      udf_d = udf_q;
    end
  end

  // Error flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= ERR_RST;
      udf_q <= ERR_RST;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wr_addr      = wr_ptr_q;
  assign rd_addr      = rd_ptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule : fifo_ptr_ctrl

// File: tb/tb_fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
// Self-checking bench for fifo_ptr_ctrl with DEPTH=10, ADDR_W=4, AF_LVL=8,
// AE_LVL=2. The reference keeps the FIFO as a queue of written addresses;
// occupancy is the queue size and the head must match rd_addr.
// ----------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 10;
  localparam int AF_LVL = 8;
  localparam int AE_LVL = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_en, rd_en;
  logic [ADDR_W:0]   count;
  logic              full, empty, almost_full, almost_empty;
  logic              overflow, underflow;

  int n_checks = 0;
  int n_errs   = 0;

  // reference state
  int m_q[$];
  int m_wr = 0;
  int m_rd = 0;
  int m_ovf = 0;
  int m_udf = 0;

  always #5 clk = ~clk;

  fifo_ptr_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_en(wr_en), .rd_en(rd_en),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int c;
    c = m_q.size();
    check_eq("wr_addr", int'(wr_addr), m_wr);
    check_eq("rd_addr", int'(rd_addr), m_rd);
    check_eq("count", int'(count), c);
    check_eq("full", int'(full), int'(c == DEPTH));
    check_eq("empty", int'(empty), int'(c == 0));
    check_eq("almost_full", int'(almost_full), int'(c >= AF_LVL));
    check_eq("almost_empty", int'(almost_empty), int'(c <= AE_LVL));
    check_eq("overflow", int'(overflow), m_ovf);
    check_eq("underflow", int'(underflow), m_udf);
  endtask

  // One clock cycle: drive, check the accept strobes, advance the model,
  // then check the registered outputs.
  task automatic step(input bit p, input bit q, input bit r);
    bit exp_we, exp_re;
    int pre;
    @(negedge clk);
    push  = p;
    pop   = q;
    rst_n = r;
    #1;
    pre    = m_q.size();
    exp_we = r && p && (pre < DEPTH);
    exp_re = r && q && (pre > 0);
    check_eq("wr_en", int'(wr_en), int'(exp_we));
    check_eq("rd_en", int'(rd_en), int'(exp_re));
    if (exp_re) check_eq("rd_head", int'(rd_addr), m_q[0]);
    @(posedge clk);
    #1;
    if (!r) begin
      m_q.delete();
      m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
    end else begin
`ifdef FIFO_PTR_ERR_EN
      if (p && pre == DEPTH) m_ovf = 1;
      if (q && pre == 0)     m_udf = 1;
`endif
      if (exp_re) begin
        void'(m_q.pop_front());
        m_rd = (m_rd + 1) % DEPTH;
      end
      if (exp_we) begin
        m_q.push_back(m_wr);
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
    check_state();
  endtask

  initial begin
    int bias;
    // reset held two cycles with push asserted: reset wins
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_empty", int'(empty), 1);

    // 10 pushes: fill and wrap wr_addr
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1);
    check_eq("fill_full", int'(full), 1);
    check_eq("fill_wr_wrap", int'(wr_addr), 0);

    // push while full: rejected
    step(1'b1, 1'b0, 1'b1);
    check_eq("full_push_count", int'(count), DEPTH);

    // push & pop at full: only pop accepted
    step(1'b1, 1'b1, 1'b1);
    check_eq("full_pp_count", int'(count), DEPTH - 1);
    step(1'b1, 1'b0, 1'b1);

    // 10 pops: drain and wrap rd_addr
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("drain_empty", int'(empty), 1);

    // pop while empty, then push & pop at empty: only push accepted
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_eq("empty_pp_count", int'(count), 1);

    // simultaneous at count=5
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_eq("mid_pp_count", int'(count), 5);

    // reset mid-stream at count=7
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check_eq("midrst_count", int'(count), 0);
    check_eq("midrst_ovf", int'(overflow), 0);

    // almost-flag thresholds while filling from empty
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1);

    // randomized traffic with alternating fill/drain bias and rare resets
    for (int i = 0; i < 2000; i++) begin
      bias = ((i / 60) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < bias,
           $urandom_range(0, 99) < (100 - bias),
           $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_fifo_ptr_ctrl

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised, registered read/write pointer controller for the lab FIFO: the sequential successor to the standalone pointer adders. It owns both pointers, wraps them at an arbitrary `DEPTH` (not limited to a power of two) and tracks occupancy. From the occupancy it derives full/empty/almost flags. Its `wr_addr`/`rd_addr` outputs drive the dual-port FIFO memory directly.

## Interface
- `ADDR_W`, 8, pointer/address width in bits.
- `DEPTH`, 256, number of entries; legal range 2..2^ADDR_W.
- `AF_LVL`, DEPTH-2, `almost_full` asserts when count >= AF_LVL.
- `AE_LVL`, 2, `almost_empty` asserts when count <= AE_LVL.
- `clk` in 1 — single clock; all state on rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `push` in 1 — write request.
- `pop` in 1 — read request.
- `wr_addr` out ADDR_W — current write pointer (memory write address).
- `rd_addr` out ADDR_W — current read pointer (memory read address).
- `wr_en` out 1 — combinational push accepted this cycle (push & ~full).
- `rd_en` out 1 — combinational pop accepted this cycle (pop & ~empty).
- `count` out ADDR_W+1 — registered occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty` out 1 — registered flags.
- `overflow`, `underflow` out 1 — sticky error flags (only with FIFO_PTR_ERR_EN).

## Operation
- Reset (rst_n=0 at clk edge): wr_addr=0, rd_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Acceptance: push accepted iff push & ~full; pop accepted iff pop & ~empty. Flags are evaluated on the pre-edge state.
- Pointer advance: next = (ptr == DEPTH-1) ? 0 : ptr+1. No modulo-2^ADDR_W wrap. Pointers never reach values >= DEPTH.
- Count: +1 on push only, -1 on pop only, unchanged when both are accepted or neither.
- Simultaneous push & pop:
  - neither full nor empty: both accepted, both pointers advance, count held.
  - empty: only the push is accepted.
  - full: only the pop is accepted.
- Flags are recomputed from the next count and registered. full = (count==DEPTH); empty = (count==0).
- Rejected requests do not change any state apart from the error flags.
- Reset mid-operation: all state returns to reset values on that edge. Requests in the same cycle are ignored.

## Timing
- Request to pointer/count/flag update: 1 cycle. The new values are visible after the edge on which the request is sampled.
- wr_en/rd_en are valid in the request cycle. The memory writes at wr_addr on the same edge.
- rd_addr points to the head entry while empty=0. Memory read latency is the memory's concern.
- Back-to-back push or pop every cycle is supported. Throughput is 1 push and 1 pop per cycle.

## Configuration
- `FIFO_PTR_ERR_EN` defined: overflow sets on push & full; underflow sets on pop & empty. Both flags stay set until reset.
- Undefined: overflow and underflow are tied to 0 and no error registers are generated.

## Structure
- Shared package `fifo_ptr_pkg`:
  - count-width rule ADDR_W+1;
  - reset constants for pointers and flags;
  - DEPTH legality check (elaboration error if DEPTH > 2^ADDR_W or DEPTH < 2).
- One sub-module, `ptr_wrap_inc` (parameters ADDR_W, DEPTH): combinational wrap-aware increment. It is instantiated twice, once per pointer.
- The top level holds the registers, acceptance logic, count and flag logic.

## Test plan
- Reset with DEPTH=256: hold rst_n=0 for 2 cycles while push=1 -> wr_addr=0, rd_addr=0, count=0, empty=1, full=0, wr_en=0 (reset wins).
- DEPTH=10, ADDR_W=4: 10 pushes then 10 pops -> wr_addr runs 0..9 then wraps to 0; full=1 after the 10th push; rd_addr returns to 0 and empty=1 after the 10th pop.
- Push while full (DEPTH=10, count=10): push=1 for 1 cycle -> wr_en=0, wr_addr and count unchanged; overflow=1 with FIFO_PTR_ERR_EN, 0 without.
- Simultaneous push & pop:
  - count=5 -> count stays 5, both pointers +1;
  - count=0 -> count=1, rd_addr unchanged;
  - count=DEPTH -> count=DEPTH-1, wr_addr unchanged.
- Almost flags with DEPTH=10, AF_LVL=8, AE_LVL=2: fill from 0 -> almost_empty drops at count=3, almost_full rises at count=8.
- Reset mid-stream at count=7: assert rst_n=0 for one edge -> all outputs return to reset values, including sticky error flags.
